// File: rtl/operand_read_fsm.sv
// Operand collector: gathers NUM_OPS isreg-qualified register reads into slots,
//   then presents the full set on regout with a valid/consume handshake.
// Latency: ops_valid/regout are visible the cycle after the final read is captured.
// Backpressure: while a set is held and consume=0, incoming reads are dropped
//   and flagged on the sticky overflow output.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   isreg, regvalue  - register-file read strobe and data
//   clear            - synchronous abort of a partial or held set (highest priority)
//   consume          - downstream accepts the held set
//   regout           - gated operand set, slot k at [k*WIDTH +: WIDTH]
//   ops_valid        - a complete set is held
//   op_count         - slots filled in the current set
//   overflow         - sticky flag: a read was dropped while holding
module operand_read_fsm #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 2,
  localparam int CW     = (NUM_OPS + 1 > 2) ? $clog2(NUM_OPS + 1) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     isreg,
  input  logic [WIDTH-1:0]         regvalue,
  input  logic                     clear,
  input  logic                     consume,
  output logic [NUM_OPS*WIDTH-1:0] regout,
  output logic                     ops_valid,
  output logic [CW-1:0]            op_count,
  output logic                     overflow
);

  localparam int IW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [NUM_OPS*WIDTH-1:0] slots_q, slots_d;
  logic                     overflow_q, overflow_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    slots_d    = slots_q;
    overflow_d = overflow_q;

    if (clear) begin
      state_d    = ST_WAIT;
      idx_d      = '0;
      slots_d    = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (isreg) begin
            for (int k = 0; k < NUM_OPS; k++) begin
              if (idx_q == IW'(k)) begin
                slots_d[k*WIDTH +: WIDTH] = regvalue;
              end
            end
            if (idx_q == IW'(NUM_OPS - 1)) begin
              state_d = ST_HOLD;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: begin // ST_HOLD
          if (consume) begin
            overflow_d = 1'b0;
            if (isreg) begin
              // Streaming: the read arriving with consume starts the next set,
              // so a continuous read stream loses no cycles.
              slots_d[WIDTH-1:0] = regvalue;
              if (NUM_OPS == 1) begin
                state_d = ST_HOLD;
              end else begin
                state_d = ST_WAIT;
                idx_d   = IW'(1);
              end
            end else begin
              state_d = ST_WAIT;
            end
          end else if (isreg) begin
            overflow_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_WAIT;
      idx_q      <= '0;
      slots_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      slots_q    <= slots_d;
      overflow_q <= overflow_d;
    end
  end

  assign ops_valid = (state_q == ST_HOLD);
  assign op_count  = ops_valid ? CW'(NUM_OPS) : CW'(idx_q);
  assign overflow  = overflow_q;
  // Stale slot contents stay hidden outside HOLD.
  assign regout    = slots_q & {(NUM_OPS*WIDTH){ops_valid}};

endmodule

// File: tb/tb_operand_read_fsm.sv
// Bench for operand_read_fsm: three instances (8x2, 8x3, 16x1) sharing clk/rst.
module tb_operand_read_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, NUM_OPS=2
  logic        a_isreg = 0, a_clear = 0, a_consume = 0;
  logic [7:0]  a_regvalue = 0;
  logic [15:0] a_regout;
  logic        a_ops_valid, a_overflow;
  logic [1:0]  a_op_count;
  // Instance B: WIDTH=8, NUM_OPS=3
  logic        b_isreg = 0, b_clear = 0, b_consume = 0;
  logic [7:0]  b_regvalue = 0;
  logic [23:0] b_regout;
  logic        b_ops_valid, b_overflow;
  logic [1:0]  b_op_count;
  // Instance C: WIDTH=16, NUM_OPS=1
  logic        c_isreg = 0, c_clear = 0, c_consume = 0;
  logic [15:0] c_regvalue = 0;
  logic [15:0] c_regout;
  logic        c_ops_valid, c_overflow;
  logic [0:0]  c_op_count;

  operand_read_fsm #(.WIDTH(8), .NUM_OPS(2)) u_dut_a (
    .clk(clk), .rst(rst), .isreg(a_isreg), .regvalue(a_regvalue), .clear(a_clear),
    .consume(a_consume), .regout(a_regout), .ops_valid(a_ops_valid),
    .op_count(a_op_count), .overflow(a_overflow));
  operand_read_fsm #(.WIDTH(8), .NUM_OPS(3)) u_dut_b (
    .clk(clk), .rst(rst), .isreg(b_isreg), .regvalue(b_regvalue), .clear(b_clear),
    .consume(b_consume), .regout(b_regout), .ops_valid(b_ops_valid),
    .op_count(b_op_count), .overflow(b_overflow));
  operand_read_fsm #(.WIDTH(16), .NUM_OPS(1)) u_dut_c (
    .clk(clk), .rst(rst), .isreg(c_isreg), .regvalue(c_regvalue), .clear(c_clear),
    .consume(c_consume), .regout(c_regout), .ops_valid(c_ops_valid),
    .op_count(c_op_count), .overflow(c_overflow));

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (a_ops_valid !== 1'b0) begin n_err++; $display("FAIL reset_a_valid got=%b exp=0", a_ops_valid); end
    n_cmp++; if (a_regout !== 16'h0) begin n_err++; $display("FAIL reset_a_regout got=%h exp=0", a_regout); end
    n_cmp++; if (a_op_count !== 2'd0) begin n_err++; $display("FAIL reset_a_count got=%0d exp=0", a_op_count); end
    n_cmp++; if (a_overflow !== 1'b0) begin n_err++; $display("FAIL reset_a_ovf got=%b exp=0", a_overflow); end
    n_cmp++; if (c_regout !== 16'h0) begin n_err++; $display("FAIL reset_c_regout got=%h exp=0", c_regout); end
    #10 rst = 1'b0; // time 12: between edges
  endtask

  task automatic test_basic();
    a_isreg = 1; a_regvalue = 8'h3C;
    tick();
    n_cmp++; if (a_op_count !== 2'd1) begin n_err++; $display("FAIL basic_count1 got=%0d exp=1", a_op_count); end
    n_cmp++; if (a_regout !== 16'h0) begin n_err++; $display("FAIL basic_regout_early got=%h exp=0", a_regout); end
    a_regvalue = 8'hA5; exp_q.push_back(32'hA53C);
    tick();
    a_isreg = 0;
    n_cmp++; if (a_ops_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b exp=1", a_ops_valid); end
    n_cmp++; if (a_op_count !== 2'd2) begin n_err++; $display("FAIL basic_count2 got=%0d exp=2", a_op_count); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (32'(a_regout) !== exp_v) begin n_err++; $display("FAIL basic_regout got=%h exp=%h", a_regout, exp_v); end
    a_consume = 1;
    tick();
    a_consume = 0;
    n_cmp++; if (a_ops_valid !== 1'b0) begin n_err++; $display("FAIL basic_consume got=%b exp=0", a_ops_valid); end
  endtask

  task automatic test_gaps_hold();
    b_isreg = 1; b_regvalue = 8'h11; tick();
    b_isreg = 0; tick(); tick();
    b_isreg = 1; b_regvalue = 8'h22; tick();
    b_isreg = 0; tick();
    n_cmp++; if (b_op_count !== 2'd2) begin n_err++; $display("FAIL gaps_count got=%0d exp=2", b_op_count); end
    b_isreg = 1; b_regvalue = 8'h33; exp_q.push_back(32'h332211); tick();
    b_isreg = 0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (b_ops_valid !== 1'b1 || 32'(b_regout) !== exp_q[0]) begin
        n_err++; $display("FAIL gaps_hold[%0d] got=%b/%h exp=1/%h", i, b_ops_valid, b_regout, exp_q[0]);
      end
      tick();
    end
    void'(exp_q.pop_front());
    b_consume = 1; tick(); b_consume = 0;
    n_cmp++; if (b_ops_valid !== 1'b0) begin n_err++; $display("FAIL gaps_consume got=%b exp=0", b_ops_valid); end
  endtask

  task automatic test_overflow();
    a_isreg = 1; a_regvalue = 8'h12; tick();
    a_regvalue = 8'h34; exp_q.push_back(32'h3412); tick();
    a_regvalue = 8'hFF; tick(); // dropped: held, consume=0
    a_isreg = 0;
    n_cmp++; if (a_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%b exp=1", a_overflow); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (32'(a_regout) !== exp_v) begin n_err++; $display("FAIL ovf_regout got=%h exp=%h", a_regout, exp_v); end
    a_consume = 1; tick(); a_consume = 0;
    n_cmp++; if (a_overflow !== 1'b0 || a_ops_valid !== 1'b0) begin
      n_err++; $display("FAIL ovf_clear got=%b/%b exp=0/0", a_overflow, a_ops_valid);
    end
  endtask

  task automatic test_streaming();
    int sets = 0;
    for (int v = 1; v <= 6; v++) begin
      a_isreg = 1; a_regvalue = 8'(v);
      a_consume = a_ops_valid;
      if (v % 2 == 0) exp_q.push_back({16'h0, 8'(v), 8'(v - 1)});
      tick();
      if (a_ops_valid === 1'b1) begin
        sets++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL stream_unexpected got=%h exp=none", a_regout);
        end else begin
          exp_v = exp_q.pop_front();
          n_cmp++; if (32'(a_regout) !== exp_v) begin n_err++; $display("FAIL stream_set got=%h exp=%h", a_regout, exp_v); end
        end
      end
      n_cmp++; if (a_overflow !== 1'b0) begin n_err++; $display("FAIL stream_ovf got=%b exp=0", a_overflow); end
    end
    n_cmp++; if (sets != 3) begin n_err++; $display("FAIL stream_sets got=%0d exp=3", sets); end
    a_isreg = 0; a_consume = 1; tick(); a_consume = 0;
    exp_q.delete();
  endtask

  task automatic test_clear();
    a_isreg = 1; a_regvalue = 8'h77; tick();
    a_clear = 1; a_regvalue = 8'h99; tick();
    a_clear = 0;
    n_cmp++; if (a_op_count !== 2'd0) begin n_err++; $display("FAIL clear_count got=%0d exp=0", a_op_count); end
    a_regvalue = 8'h01; tick();
    n_cmp++; if (a_op_count !== 2'd1) begin n_err++; $display("FAIL clear_fresh_count got=%0d exp=1", a_op_count); end
    a_regvalue = 8'h02; exp_q.push_back(32'h0201); tick();
    a_isreg = 0;
    exp_v = exp_q.pop_front();
    n_cmp++; if (a_ops_valid !== 1'b1 || 32'(a_regout) !== exp_v) begin
      n_err++; $display("FAIL clear_fresh_set got=%b/%h exp=1/%h", a_ops_valid, a_regout, exp_v);
    end
  endtask

  task automatic test_async_reset();
    // A is holding 0x0201 here.
    #2 rst = 1;
    #1;
    n_cmp++; if (a_ops_valid !== 1'b0 || a_regout !== 16'h0) begin
      n_err++; $display("FAIL arst_hold got=%b/%h exp=0/0", a_ops_valid, a_regout);
    end
    #1 rst = 0;
    a_isreg = 1; a_regvalue = 8'h55; tick();
    a_isreg = 0;
    #2 rst = 1;
    #1;
    n_cmp++; if (a_op_count !== 2'd0) begin n_err++; $display("FAIL arst_midset got=%0d exp=0", a_op_count); end
    #1 rst = 0;
    a_isreg = 1; a_regvalue = 8'h66; tick();
    a_regvalue = 8'h77; exp_q.push_back(32'h7766); tick();
    a_isreg = 0;
    exp_v = exp_q.pop_front();
    n_cmp++; if (32'(a_regout) !== exp_v) begin n_err++; $display("FAIL arst_newset got=%h exp=%h", a_regout, exp_v); end
  endtask

  task automatic test_num_ops1();
    c_isreg = 1; c_regvalue = 16'hBEEF; exp_q.push_back(32'hBEEF); tick();
    c_isreg = 0;
    exp_v = exp_q.pop_front();
    n_cmp++; if (c_ops_valid !== 1'b1 || c_op_count !== 1'b1 || 32'(c_regout) !== exp_v) begin
      n_err++; $display("FAIL n1_first got=%b/%0d/%h exp=1/1/%h", c_ops_valid, c_op_count, c_regout, exp_v);
    end
    c_consume = 1; c_isreg = 1; c_regvalue = 16'h1234; exp_q.push_back(32'h1234); tick();
    c_consume = 0; c_isreg = 0;
    exp_v = exp_q.pop_front();
    n_cmp++; if (c_ops_valid !== 1'b1 || 32'(c_regout) !== exp_v || c_overflow !== 1'b0) begin
      n_err++; $display("FAIL n1_stream got=%b/%h/%b exp=1/%h/0", c_ops_valid, c_regout, c_overflow, exp_v);
    end
    c_consume = 1; tick(); c_consume = 0;
    n_cmp++; if (c_ops_valid !== 1'b0 || c_regout !== 16'h0) begin
      n_err++; $display("FAIL n1_drain got=%b/%h exp=0/0", c_ops_valid, c_regout);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_gaps_hold();
    test_overflow();
    test_streaming();
    test_clear();
    test_async_reset();
    test_num_ops1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_read_fsm.md
# operand_read_fsm

Parametrised operand collector for the matrix datapath. It captures a run of NUM_OPS register reads, each qualified by `isreg`, from the register-file read bus into internal slots. It then presents the completed operand set as one gated bus with a valid/consume handshake. It supersedes the fixed two-read, single-pass capture logic by adding configurable width and operand count, a hold state with backpressure, overflow detection, a synchronous clear, and back-to-back streaming.

## Interface
Parameters:
- WIDTH, 8, bit width of one register value
- NUM_OPS, 2, reads per operand set (legal range 1..16)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- isreg  input  1  `regvalue` carries a valid register read this cycle
- regvalue  input  WIDTH  register read data
- clear  input  1  synchronous abort; discards a partial or held set
- consume  input  1  downstream accepts the held set
- regout  output  NUM_OPS*WIDTH  operand set; slot k occupies bits [k*WIDTH +: WIDTH]; all zeros unless `ops_valid`
- ops_valid  output  1  complete set held
- op_count  output  CW=max(1,$clog2(NUM_OPS+1))  number of slots filled in the current set
- overflow  output  1  sticky; a read was dropped while holding

## Operation
- The FSM has two states:
  - WAIT: collecting reads; `ops_valid`=0.
  - HOLD: a full set is held; `ops_valid`=1.
- Write index `idx` runs 0..NUM_OPS-1. `op_count` equals `idx` in WAIT and NUM_OPS in HOLD.
- WAIT behaviour:
  - `isreg`=1: slot[idx] <= `regvalue`.
  - If idx==NUM_OPS-1: go to HOLD and set idx <= 0.
  - Otherwise: idx <= idx+1.
  - `isreg`=0: hold all state.
- HOLD behaviour:
  - `consume`=1, `isreg`=0: go to WAIT; clear `overflow`.
  - `consume`=1, `isreg`=1 (streaming): clear `overflow`; slot[0] <= `regvalue`.
    - If NUM_OPS==1: stay in HOLD.
    - Otherwise: go to WAIT with idx=1.
  - `consume`=0, `isreg`=1: drop the read; slots are unchanged; `overflow` <= 1.
  - `consume`=0, `isreg`=0: hold.
- `consume` in WAIT is ignored.
- `clear` has the highest priority of all synchronous inputs:
  - state <= WAIT, idx <= 0, all slots <= 0, `overflow` <= 0.
  - `isreg` and `consume` in the same cycle are ignored.
- `regout` is combinational: the slot concatenation ANDed with `ops_valid`.
- Slots keep their stale contents in WAIT. Only `clear` and `rst` zero them.

## Timing
- Reset: state=WAIT, idx=0, slots=0, `regout`=0, `ops_valid`=0, `op_count`=0, `overflow`=0.
  - Takes effect immediately when `rst` asserts, independent of `clk`.
  - The first capture can occur on the first rising edge with `rst` low.
- Latency:
  - `ops_valid` rises on the edge that captures the final read, and is visible the following cycle.
  - `regout` is valid in that same cycle.
- `ops_valid` falls on the edge where `consume`=1.
- Throughput: with `isreg` held at 1 and `consume` asserted on every HOLD cycle, one set completes every NUM_OPS cycles and no reads are dropped.
- `overflow` sets on the edge after the dropped read, and stays set until `consume` or `clear`.
- Reset mid-set: the partial set is lost and the next read goes to slot 0.
- A reset pulse during HOLD clears `ops_valid` immediately (asynchronously).

## Test plan
- Basic capture (WIDTH=8, NUM_OPS=2):
  - Stimulus: after reset, `isreg`=1 with 0x3C, then `isreg`=1 with 0xA5.
  - Response: the next cycle shows `ops_valid`=1 and `regout`=0xA53C; `op_count` steps 0→1→2; `regout`=0 before that.
- Gaps and hold (NUM_OPS=3):
  - Stimulus: reads 0x11, idle 2 cycles, 0x22, idle, 0x33; then `consume` held low for 5 cycles.
  - Response: `regout`=0x332211 held stable with `ops_valid`=1 for all 5 cycles; `consume`=1 drops `ops_valid` the next cycle.
- Overflow:
  - Stimulus: in HOLD with `consume`=0, `isreg`=1 with 0xFF.
  - Response: `regout` unchanged and `overflow`=1 next cycle; `consume` clears `overflow` and `ops_valid`.
- Streaming (NUM_OPS=2):
  - Stimulus: `isreg`=1 every cycle with 1,2,3,4,5,6; `consume`=1 whenever `ops_valid`=1.
  - Response: sets 0x0201, 0x0403, 0x0605 in consecutive valid windows; `overflow` never set.
- Clear and async reset:
  - Stimulus: one read 0x77, then `clear`=1 together with `isreg`=1.
  - Response: `op_count`=0 and the read is ignored; the next two reads form a fresh set.
  - Stimulus: assert `rst` between clock edges while in HOLD.
  - Response: `ops_valid` and `regout` go to 0 immediately.
- NUM_OPS=1, WIDTH=16:
  - Stimulus: read 0xBEEF, then `consume`=1 together with `isreg`=1 carrying 0x1234.
  - Response: `regout`=0xBEEF; then the state stays HOLD with `regout`=0x1234.
